// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port synchronous data RAM between the CPU load/store path and the
//   VGA display reader. One access is granted per cycle. VGA wins by default, but a CPU
//   request that has waited MAX_WAIT cycles is forced through. Read data returns one cycle
//   after the grant and is routed to the requester that issued the read.
//
// Ports
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   cpu_req/we/addr/wdata      CPU access request (level, held until granted)
//   cpu_gnt, cpu_stall         CPU issued this cycle / CPU request denied this cycle
//   cpu_rvalid, cpu_rdata      CPU read return (zero when not valid)
//   vga_req/addr               VGA read request
//   vga_gnt                    VGA read issued this cycle
//   vga_rvalid, vga_rdata      VGA read return (zero when not valid)
//   ram_addr/wdata/we          RAM command from the winner (all zero when idle)
//   ram_rdata                  RAM synchronous read data
//   vga_miss_cnt               saturating count of denied VGA requests
module ram_port_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_gnt,
    output logic          vga_rvalid,
    output logic [DW-1:0] vga_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic [7:0]    vga_miss_cnt
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] rtag_q, rtag_d;
    logic [7:0] miss_cnt_q, miss_cnt_d;
    logic       force_cpu;

    // Arbitration and RAM command mux
    always_comb begin
        force_cpu = cpu_req & (wait_cnt_q == MaxWait);
        vga_gnt   = vga_req & ~force_cpu;
        cpu_gnt   = cpu_req & ~vga_gnt;
        cpu_stall = cpu_req & ~cpu_gnt;

        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (vga_gnt) begin
            ram_addr = vga_addr;
        end else if (cpu_gnt) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end
    end

    // Next-state logic
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!cpu_req || cpu_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < MaxWait) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        // Bit 1 tags a VGA read, bit 0 a CPU read; writes return nothing.
        rtag_d = {vga_gnt, cpu_gnt & ~cpu_we};

        miss_cnt_d = miss_cnt_q;
        if (vga_req && !vga_gnt && miss_cnt_q != 8'hFF) begin
            miss_cnt_d = miss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            rtag_q     <= '0;
            miss_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rtag_q     <= rtag_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Read return routing
    always_comb begin
        cpu_rvalid   = rtag_q[0];
        vga_rvalid   = rtag_q[1];
        cpu_rdata    = rtag_q[0] ? ram_rdata : '0;
        vga_rdata    = rtag_q[1] ? ram_rdata : '0;
        vga_miss_cnt = miss_cnt_q;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_gnt, cpu_stall, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       vga_req;
    logic [7:0] vga_addr;
    logic       vga_gnt, vga_rvalid;
    logic [7:0] vga_rdata;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_we;
    logic [7:0] vga_miss_cnt;

    logic [7:0] mem [256];
    logic [7:0] cpu_q [$];
    logic [7:0] vga_q [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.AW(8), .DW(8), .MAX_WAIT(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_stall   (cpu_stall),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .vga_req     (vga_req),
        .vga_addr    (vga_addr),
        .vga_gnt     (vga_gnt),
        .vga_rvalid  (vga_rvalid),
        .vga_rdata   (vga_rdata),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata),
        .vga_miss_cnt(vga_miss_cnt)
    );

    // Synchronous single-port RAM model
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a read return is presented
    always @(negedge clk) begin
        if (!reset) begin
            check("cpu_stall", cpu_stall, cpu_req & ~cpu_gnt);
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 1, 0);
                else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
            end else if (cpu_rdata !== 8'h00) begin
                check("cpu_rdata_idle", cpu_rdata, 0);
            end
            if (vga_rvalid) begin
                if (vga_q.size() == 0) check("vga_rvalid_unexpected", 1, 0);
                else check("vga_rdata", vga_rdata, vga_q.pop_front());
            end else if (vga_rdata !== 8'h00) begin
                check("vga_rdata_idle", vga_rdata, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        vga_req = 0; vga_addr = 0;
    endtask

    // Contention cycle: V,V,V,C pattern when both requests are held from wait_cnt = 0
    task automatic contend(input int i, input logic [7:0] exp_miss);
        logic c;
        c = (i % 4) == 3;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        vga_req = 1; vga_addr = 8'h00;
        if (c) cpu_q.push_back(8'h5A);
        else vga_q.push_back(8'hA0);
        @(negedge clk);
        check("cont_vga_gnt", vga_gnt, !c);
        check("cont_cpu_gnt", cpu_gnt, c);
        check("cont_stall", cpu_stall, !c);
        check("cont_miss_cnt", vga_miss_cnt, exp_miss);
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h5A;
        for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);
        idle();
        reset = 1;

        // Reset state
        @(negedge clk);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_vga_rvalid", vga_rvalid, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_vga_rdata", vga_rdata, 0);
        check("rst_miss_cnt", vga_miss_cnt, 0);
        check("rst_ram_we", ram_we, 0);
        step();
        reset = 0;
        step();

        // CPU read 0x10
        cpu_req = 1; cpu_addr = 8'h10; cpu_q.push_back(8'h5A);
        @(negedge clk);
        check("rd_cpu_gnt", cpu_gnt, 1);
        check("rd_ram_addr", ram_addr, 8'h10);
        step();
        idle();
        step();

        // CPU write 0x33 to 0x20, then read it back
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 8'h33;
        @(negedge clk);
        check("wr_cpu_gnt", cpu_gnt, 1);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 8'h20);
        check("wr_ram_wdata", ram_wdata, 8'h33);
        step();
        cpu_we = 0; cpu_wdata = 0; cpu_q.push_back(8'h33);
        @(negedge clk);
        check("rb_cpu_gnt", cpu_gnt, 1);
        check("rb_ram_we", ram_we, 0);
        step();
        idle();
        @(negedge clk);
        check("idle_ram_addr", ram_addr, 0);
        step();

        // Sustained contention
        for (int i = 0; i < 8; i++) contend(i, (i < 4) ? 8'd0 : 8'd1);
        idle();
        @(negedge clk);
        check("cont_final_miss", vga_miss_cnt, 2);
        step();

        // VGA stream 0x00..0x03
        for (int i = 0; i < 4; i++) begin
            vga_req = 1; vga_addr = 8'(i); vga_q.push_back(8'hA0 + 8'(i));
            @(negedge clk);
            check("vs_vga_gnt", vga_gnt, 1);
            check("vs_ram_addr", ram_addr, 8'(i));
            step();
        end
        idle();
        step();

        // Reset between a read grant and its return
        cpu_req = 1; cpu_addr = 8'h10;
        @(negedge clk);
        check("rr_cpu_gnt", cpu_gnt, 1);
        step();
        idle();
        reset = 1;
        @(negedge clk);
        check("rr_cpu_rvalid", cpu_rvalid, 0);
        check("rr_cpu_rdata", cpu_rdata, 0);
        check("rr_miss_cnt", vga_miss_cnt, 0);
        step();
        reset = 0;
        step();
        cpu_req = 1; cpu_addr = 8'h20; cpu_q.push_back(8'h33);
        @(negedge clk);
        check("rr2_cpu_gnt", cpu_gnt, 1);
        step();
        idle();
        step();

        // Contention after reset restarts the pattern; 325 denials saturate the counter
        for (int i = 0; i < 1300; i++) begin
            int n;
            n = i / 4;
            contend(i, (n > 255) ? 8'd255 : 8'(n));
        end
        idle();
        @(negedge clk);
        check("sat_miss_cnt", vga_miss_cnt, 255);
        step();
        step();
        step();

        check("cpu_q_empty", cpu_q.size(), 0);
        check("vga_q_empty", vga_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
